// File: rtl/dsp_fetch_unit.sv
// dsp_fetch_unit: instruction fetch front end.
// Issues sequential reads to a one-cycle-latency instruction memory.
// Returned words go into a 2-entry buffer that feeds decode.
// Jumps redirect the PC, flush the buffer and kill the outstanding read.
//
// Handshake: decode takes a word when instr_valid and instr_ready are both 1
// in the same cycle. instr_valid never depends on instr_ready. While a word is
// offered and not taken, instr/instr_pc hold.
//
// Credit rule: a read may issue only if the buffered words plus the read in
// flight stay below the buffer depth after this cycle's pop. The pop is
// credited in the same cycle so that a continuously ready decode receives one
// word per cycle. The buffer can still never hold more than two words.
module dsp_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               jump_flag,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               imem_re,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;

    // Outstanding read: valid while its data is due on imem_rdata this cycle.
    logic                tag_valid;
    logic [ADDR_W-1:0]   tag_pc;

    // Two-entry output buffer of {instr, instr_pc}.
    logic [INSTR_W-1:0]  fifo_instr [0:1];
    logic [ADDR_W-1:0]   fifo_pc    [0:1];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;

    logic                pop;
    logic                push;
    logic [2:0]          used;

    // Transfer to decode. A jump discards the head anyway, so the pop is moot.
    assign pop  = (count != 2'd0) && instr_ready;
    // The returning word is kept unless a jump kills it in this same cycle.
    assign push = tag_valid && !jump_flag;
    // Credits still held after this cycle's pop.
    assign used = {1'b0, count} + {2'b00, tag_valid} - {2'b00, pop};

    assign imem_re     = (state == RUN) && en && !jump_flag && (used < 3'd2);
    assign imem_addr   = pc;
    assign instr_valid = (count != 2'd0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    // Run/idle control; running is the registered view of the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Program counter: a jump overrides, otherwise advance on every issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (jump_flag) begin
            pc <= jump_addr;
        end else if (imem_re) begin
            pc <= pc + 1'b1;
        end
    end

    // In-flight tag: remembers the address whose data returns next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid <= 1'b0;
            tag_pc    <= '0;
        end else if (jump_flag) begin
            tag_valid <= 1'b0;
        end else begin
            tag_valid <= imem_re;
            if (imem_re) begin
                tag_pc <= pc;
            end
        end
    end

    // Output buffer: a jump flushes it, otherwise push the returned word and pop on transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (jump_flag) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]    <= tag_pc;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_dsp_fetch_unit.sv
// Bench for dsp_fetch_unit.
// The memory model returns {~addr, addr} one cycle after each read strobe.
// It returns random data in all other cycles.
// Expected instruction addresses are queued as scenarios are driven.
// A monitor pops the queue on every transfer and compares the word.
module tb_dsp_fetch_unit;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               rst;
  logic               en;
  logic               jump_flag;
  logic [ADDR_W-1:0]  jump_addr;
  logic               imem_re;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               running;

  int checks   = 0;
  int failures = 0;
  logic [ADDR_W-1:0] exp_q[$];

  dsp_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .jump_flag  (jump_flag),
    .jump_addr  (jump_addr),
    .imem_re    (imem_re),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .running    (running)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instruction memory: one-cycle read latency, garbage when not read
  always @(posedge clk) begin
    if (imem_re) imem_rdata <= {~imem_addr, imem_addr};
    else         imem_rdata <= $urandom();
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", tag, act, req, $time);
    end
  endtask

  // scoreboard monitor: every transfer must match the next queued address
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      end else begin
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", {16'h0, instr_pc}, {16'h0, e});
        chk("sb_data", instr, {~e, e});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load_exp(input logic [ADDR_W-1:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + ADDR_W'(i));
  endtask

  initial begin
    rst         = 1'b0;
    en          = 1'b0;
    jump_flag   = 1'b0;
    jump_addr   = '0;
    instr_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    sample();
    chk("rst_re", imem_re, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);

    next_cycle(); rst = 1'b1;
    sample();
    chk("idle_re", imem_re, 0);

    // ---- scenario 1: start-up and streaming ----
    next_cycle(); en = 1'b1; load_exp(16'h0000, 64);
    sample();
    chk("s1_t0_re", imem_re, 0);
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      sample();
      chk("s1_re", imem_re, 1);
      chk("s1_addr", imem_addr, 32'(i - 1));
      chk("s1_running", running, 1);
      if (i >= 3) begin
        chk("s1_valid", instr_valid, 1);
        chk("s1_pc", instr_pc, 32'(i - 3));
      end else begin
        chk("s1_valid_lat", instr_valid, 0);
      end
    end

    // ---- scenario 2: decode stalls for 6 cycles ----
    for (int i = 0; i < 6; i++) begin
      next_cycle(); instr_ready = 1'b0;
      sample();
      chk("s2_re_stall", imem_re, 0);
      chk("s2_valid", instr_valid, 1);
      chk("s2_hold_pc", instr_pc, 16'h0008);
      chk("s2_hold_instr", instr, {~16'h0008, 16'h0008});
    end
    next_cycle(); instr_ready = 1'b1;
    sample();
    chk("s2_rel_pc", instr_pc, 16'h0008);
    chk("s2_rel_re", imem_re, 1);
    chk("s2_rel_addr", imem_addr, 16'h000A);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      chk("s2_seq_pc", instr_pc, 32'(9 + i));
      chk("s2_seq_valid", instr_valid, 1);
    end

    // ---- scenario 3: jump to 0x0040 with words buffered and in flight ----
    next_cycle(); jump_flag = 1'b1; jump_addr = 16'h0040;
    sample();
    chk("s3_jump_re", imem_re, 0);
    next_cycle(); jump_flag = 1'b0; load_exp(16'h0040, 32);
    sample();
    chk("s3_t1_valid", instr_valid, 0);
    chk("s3_t1_re", imem_re, 1);
    chk("s3_t1_addr", imem_addr, 16'h0040);
    next_cycle();
    sample();
    chk("s3_t2_valid", instr_valid, 0);
    chk("s3_t2_addr", imem_addr, 16'h0041);
    next_cycle();
    sample();
    chk("s3_t3_valid", instr_valid, 1);
    chk("s3_t3_pc", instr_pc, 16'h0040);
    next_cycle();
    sample();
    chk("s3_t4_pc", instr_pc, 16'h0041);

    // ---- scenario 4: back-to-back jumps, last one (0xFFFE) wins, PC wraps ----
    next_cycle(); jump_flag = 1'b1; jump_addr = 16'h1234;
    sample();
    chk("s4_j0_re", imem_re, 0);
    next_cycle(); jump_addr = 16'hFFFE;
    sample();
    chk("s4_j1_re", imem_re, 0);
    chk("s4_j1_valid", instr_valid, 0);
    next_cycle(); jump_flag = 1'b0; load_exp(16'hFFFE, 32);
    sample();
    chk("s4_issue_addr", imem_addr, 16'hFFFE);
    chk("s4_issue_re", imem_re, 1);
    next_cycle();
    sample();
    chk("s4_wrap_addr", imem_addr, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      logic [ADDR_W-1:0] p;
      p = 16'hFFFE + ADDR_W'(i);
      next_cycle();
      sample();
      chk("s4_pc", instr_pc, p);
      chk("s4_valid", instr_valid, 1);
    end

    // ---- scenario 5: en drop mid-run, drain, resume ----
    next_cycle(); en = 1'b0;
    sample();
    chk("s5_re_now", imem_re, 0);
    chk("s5_running_still", running, 1);
    chk("s5_pc0", instr_pc, 16'h0002);
    next_cycle();
    sample();
    chk("s5_running_off", running, 0);
    chk("s5_drain_valid", instr_valid, 1);
    chk("s5_drain_pc", instr_pc, 16'h0003);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      sample();
      chk("s5_empty", instr_valid, 0);
      chk("s5_idle_re", imem_re, 0);
      chk("s5_pc_hold", imem_addr, 16'h0004);
    end
    next_cycle(); en = 1'b1;
    sample();
    chk("s5_en_re", imem_re, 0);
    next_cycle();
    sample();
    chk("s5_resume_re", imem_re, 1);
    chk("s5_resume_addr", imem_addr, 16'h0004);
    next_cycle();
    sample();
    chk("s5_resume_lat", instr_valid, 0);
    next_cycle();
    sample();
    chk("s5_resume_pc", instr_pc, 16'h0004);

    // ---- scenario 6: reset while the buffer is full ----
    next_cycle(); instr_ready = 1'b0;
    sample();
    chk("s6_fill_pc", instr_pc, 16'h0005);
    next_cycle();
    sample();
    chk("s6_full_re", imem_re, 0);
    chk("s6_full_valid", instr_valid, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("s6_rst_valid", instr_valid, 0);
    chk("s6_rst_re", imem_re, 0);
    chk("s6_rst_running", running, 0);
    chk("s6_rst_pc", instr_pc, 0);
    chk("s6_rst_instr", instr, 0);
    load_exp(16'h0000, 200);
    next_cycle(); instr_ready = 1'b1;
    next_cycle(); rst = 1'b1;
    sample();
    chk("s6_rel_re", imem_re, 0);
    chk("s6_rel_valid", instr_valid, 0);
    next_cycle();
    sample();
    chk("s6_first_addr", imem_addr, 16'h0000);
    chk("s6_no_stale1", instr_valid, 0);
    next_cycle();
    sample();
    chk("s6_no_stale2", instr_valid, 0);
    next_cycle();
    sample();
    chk("s6_first_valid", instr_valid, 1);
    chk("s6_first_pc", instr_pc, 16'h0000);

    // ---- random decode back-pressure: order must survive any ready pattern ----
    for (int i = 0; i < 80; i++) begin
      next_cycle(); instr_ready = 1'($urandom_range(0, 1));
    end

    // ---- stop and drain ----
    next_cycle(); en = 1'b0; instr_ready = 1'b1;
    repeat (5) next_cycle();
    sample();
    chk("end_empty", instr_valid, 0);
    chk("end_re", imem_re, 0);
    chk("end_running", running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
